// File: rtl/mux_scan_pkg.sv
// Shared types for the multi-channel input scanner.
// Channel state encoding and the meaning of the shared mode input.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        DIS = 2'd0,
        DIR = 2'd1,
        SCN = 2'd2
    } chan_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_chan.sv
// One scanner channel: N:1 registered selector with an auto-scan sequencer.
//   state | meaning
//   DIS   | disabled, outputs low, scan position cleared
//   DIR   | direct mode, input picked by sel
//   SCN   | scan mode, input picked by internal idx stepping every DWELL cycles
module mux_scan_chan
    import mux_scan_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    data,
    input  logic [SELW-1:0]   sel,
    input  logic              en_n,
    input  logic              mode,
    output logic [W-1:0]      y,
    output logic [SELW-1:0]   y_sel,
    output logic              y_vld,
    output logic              wrap
);

    localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SELW-1:0] IDX_LAST   = SELW'(N - 1);
    localparam logic [SELW:0]   N_EXT      = (SELW + 1)'(N);

    chan_state_t     state, state_nxt;
    logic [SELW-1:0] idx, idx_nxt, cur_idx, y_sel_nxt;
    logic [DW-1:0]   dwell, dwell_nxt, cur_dwell;
    logic [W-1:0]    y_nxt;
    logic            y_vld_nxt, wrap_nxt;

    function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input logic [SELW-1:0] s);
        pick = '0;
        for (int k = 0; k < N; k++) begin
            if (s == SELW'(k)) pick = d[k*W +: W];
        end
    endfunction

    always_comb begin
        state_nxt = DIS;
        idx_nxt   = '0;
        dwell_nxt = '0;
        y_nxt     = '0;
        y_sel_nxt = '0;
        y_vld_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        // Entering SCN from another state always starts from input 0.
        cur_idx   = (state == SCN) ? idx   : '0;
        cur_dwell = (state == SCN) ? dwell : '0;
        if (!en_n) begin
            if (mode == MODE_DIRECT) begin
                state_nxt = DIR;
                y_sel_nxt = sel;
                y_vld_nxt = ({1'b0, sel} < N_EXT);
                y_nxt     = y_vld_nxt ? pick(data, sel) : '0;
            end else begin
                state_nxt = SCN;
                y_sel_nxt = cur_idx;
                y_vld_nxt = 1'b1;
                y_nxt     = pick(data, cur_idx);
                if (cur_dwell == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (cur_idx == IDX_LAST) begin
                        idx_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        idx_nxt = cur_idx + 1'b1;
                    end
                end else begin
                    dwell_nxt = cur_dwell + 1'b1;
                    idx_nxt   = cur_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIS;
            idx   <= '0;
            dwell <= '0;
            y     <= '0;
            y_sel <= '0;
            y_vld <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            dwell <= dwell_nxt;
            y     <= y_nxt;
            y_sel <= y_sel_nxt;
            y_vld <= y_vld_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: rtl/mux_scan_nch.sv
// CH independent N:1 registered selectors with per-channel auto-scan.
// Only port slicing lives here; all behaviour is in mux_scan_chan.
module mux_scan_nch
    import mux_scan_pkg::*;
#(
    parameter  int CH    = 2,
    parameter  int N     = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH*N*W-1:0]    i_data,
    input  logic [CH*SELW-1:0]   sel,
    input  logic [CH-1:0]        en_n,
    input  logic                 mode,
    output logic [CH*W-1:0]      y,
    output logic [CH*SELW-1:0]   y_sel,
    output logic [CH-1:0]        y_vld,
    output logic [CH-1:0]        wrap
);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        mux_scan_chan #(
            .N     (N),
            .W     (W),
            .DWELL (DWELL)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .data  (i_data[c*N*W +: N*W]),
            .sel   (sel[c*SELW +: SELW]),
            .en_n  (en_n[c]),
            .mode  (mode),
            .y     (y[c*W +: W]),
            .y_sel (y_sel[c*SELW +: SELW]),
            .y_vld (y_vld[c]),
            .wrap  (wrap[c])
        );
    end

endmodule
